// File: rtl/disp_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
//   scan_state_e : controller FSM states
//   disp_word_t  : one display word {blank, points, hexs}
//   hex_nibble() : selects the nibble that belongs to a digit
package disp_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned HEX_W      = NUM_DIGITS * NIB_W;
  localparam int unsigned WORD_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2
  } scan_state_e;

  // Bit order matches the flat {blank, points, hexs} load word.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] points;
    logic [HEX_W-1:0]      hexs;
  } disp_word_t;

  function automatic logic [NIB_W-1:0] hex_nibble(input logic [HEX_W-1:0] hexs,
                                                 input logic [1:0]       k);
    return hexs[{k, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_timer.sv
// scan_timer: loadable down-counter that times DRIVE and GUARD intervals.
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_value this cycle (takes priority over counting)
//   i_value    : interval length in cycles
//   o_count    : current count (registered)
//   o_done_c   : last cycle of the interval (count == 1), combinational
module scan_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_count,
  output logic         o_done_c
);

  logic [W-1:0] r_count;

  // Loaded with N on entry, so count==1 marks the Nth cycle in the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_done_c = (r_count == W'(1));

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// A word offered with load/ready goes into a pending register, is moved to
// the shadow register in IDLE or at a frame boundary, and the shadow is
// scanned digit by digit: DWELL cycles driven, GUARD cycles all-dark.
//   clk, rst_n      : clock, async active-low reset
//   hexs/points/blank, load : display word and its valid strobe
//   ready           : a load is accepted this cycle
//   dec_d, dec_point, dec_le : decoder nibble, point, blank (1 = dark)
//   an              : active-low digit anodes
//   frame_tick      : one-cycle pulse on the last cycle of each frame
module disp_scan_ctrl
  import disp_scan_pkg::*;
#(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned GUARD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HEX_W-1:0]      hexs,
  input  logic [NUM_DIGITS-1:0] points,
  input  logic [NUM_DIGITS-1:0] blank,
  input  logic                  load,
  output logic                  ready,
  output logic [NIB_W-1:0]      dec_d,
  output logic                  dec_point,
  output logic                  dec_le,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int unsigned MAX_INT    = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int unsigned TW         = $clog2(MAX_INT + 1);
  localparam logic [1:0]  LAST_DIGIT = 2'(NUM_DIGITS - 1);

  // Registered state
  scan_state_e           r_state;
  logic [1:0]            r_idx;
  disp_word_t            r_pend;
  logic                  r_pend_v;
  disp_word_t            r_shadow;
  logic                  r_ready;
  logic [NUM_DIGITS-1:0] r_an;
  logic [NIB_W-1:0]      r_dec_d;
  logic                  r_dec_point;
  logic                  r_dec_le;
  logic                  r_frame_tick;

  // Next-state values
  scan_state_e           w_state_nxt;
  logic [1:0]            w_idx_nxt;
  disp_word_t            w_pend_nxt;
  logic                  w_pend_v_nxt;
  disp_word_t            w_shadow_nxt;
  logic                  w_ready_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [NIB_W-1:0]      w_dec_d_nxt;
  logic                  w_dec_point_nxt;
  logic                  w_dec_le_nxt;
  logic                  w_frame_tick_nxt;

  logic                  w_enter_drive;
  logic [1:0]            w_drive_idx;
  logic [NUM_DIGITS-1:0] w_an_sel;

  logic                  w_tmr_load;
  logic [TW-1:0]         w_tmr_value;
  logic [TW-1:0]         w_tmr_count;
  logic                  w_tmr_done;

  logic [WORD_W-1:0]     w_load_bits;
  disp_word_t            w_load_word;
  logic                  w_accept;
  logic                  w_frame_end;
  logic                  w_commit;

  assign w_load_bits = {blank, points, hexs};
  assign w_load_word = disp_word_t'(w_load_bits);
  assign w_accept    = load && r_ready;
  assign w_frame_end = (r_state == ST_GUARD) && (r_idx == LAST_DIGIT) && w_tmr_done;
  // Pending only moves to the shadow while idle or on the frame's last cycle.
  assign w_commit    = r_pend_v && ((r_state == ST_IDLE) || w_frame_end);

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tmr_load),
    .i_value  (w_tmr_value),
    .o_count  (w_tmr_count),
    .o_done_c (w_tmr_done)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 2'd0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_shadow     <= '0;
      r_ready      <= 1'b1;
      r_an         <= '1;
      r_dec_d      <= '0;
      r_dec_point  <= 1'b0;
      r_dec_le     <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_v     <= w_pend_v_nxt;
      r_shadow     <= w_shadow_nxt;
      r_ready      <= w_ready_nxt;
      r_an         <= w_an_nxt;
      r_dec_d      <= w_dec_d_nxt;
      r_dec_point  <= w_dec_point_nxt;
      r_dec_le     <= w_dec_le_nxt;
      r_frame_tick <= w_frame_tick_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_pend_nxt       = r_pend;
    w_pend_v_nxt     = r_pend_v;
    w_shadow_nxt     = r_shadow;
    w_ready_nxt      = r_ready;
    w_an_nxt         = r_an;
    w_dec_d_nxt      = r_dec_d;
    w_dec_point_nxt  = r_dec_point;
    w_dec_le_nxt     = r_dec_le;
    w_frame_tick_nxt = 1'b0;
    w_enter_drive    = 1'b0;
    w_drive_idx      = r_idx;
    w_an_sel         = '0;
    w_tmr_load       = 1'b0;
    w_tmr_value      = '0;

    // ready is low whenever pending is occupied, so commit and accept never overlap.
    if (w_commit) begin
      w_shadow_nxt = r_pend;
      w_pend_v_nxt = 1'b0;
      w_ready_nxt  = 1'b1;
    end else if (w_accept) begin
      w_pend_nxt   = w_load_word;
      w_pend_v_nxt = 1'b1;
      w_ready_nxt  = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_commit) begin
          w_enter_drive = 1'b1;
          w_drive_idx   = 2'd0;
        end
      end
      ST_DRIVE: begin
        if (w_tmr_done) begin
          w_state_nxt  = ST_GUARD;
          w_tmr_load   = 1'b1;
          w_tmr_value  = TW'(GUARD);
          w_an_nxt     = '1;
          w_dec_le_nxt = 1'b1;
          // A one-cycle guard on the last digit is itself the frame boundary.
          if ((r_idx == LAST_DIGIT) && (GUARD == 1)) begin
            w_frame_tick_nxt = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (w_tmr_done) begin
          w_enter_drive = 1'b1;
          w_drive_idx   = r_idx + 2'd1;
        end else if ((r_idx == LAST_DIGIT) &&
                     ({1'b0, w_tmr_count} == (TW + 1)'(2))) begin
          // Registered tick lands on the final guard cycle.
          w_frame_tick_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Digit outputs come from the post-commit shadow so a new word starts on digit 0.
    if (w_enter_drive) begin
      w_state_nxt     = ST_DRIVE;
      w_idx_nxt       = w_drive_idx;
      w_tmr_load      = 1'b1;
      w_tmr_value     = TW'(DWELL);
      w_an_sel        = 4'b0001 << w_drive_idx;
      w_an_nxt        = ~w_an_sel;
      w_dec_d_nxt     = hex_nibble(w_shadow_nxt.hexs, w_drive_idx);
      w_dec_point_nxt = w_shadow_nxt.points[w_drive_idx];
      w_dec_le_nxt    = w_shadow_nxt.blank[w_drive_idx];
    end
  end

  assign ready      = r_ready;
  assign dec_d      = r_dec_d;
  assign dec_point  = r_dec_point;
  assign dec_le     = r_dec_le;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 50000, SHALL set the clock cycles each digit is driven (legal range >= 1).
REQ-002 Parameter GUARD, default 16, SHALL set the all-anodes-off cycles between digits (legal range >= 1).
REQ-003 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 hexs  in  16  four hex nibbles; nibble k is [4k+3:4k] and belongs to digit k.
REQ-006 points  in  4  decimal-point request; bit k belongs to digit k.
REQ-007 blank  in  4  per-digit blank; bit k = 1 blanks digit k.
REQ-008 load  in  1  source offers {hexs, points, blank} this cycle.
REQ-009 ready  out  1  controller can accept a load this cycle.
REQ-010 dec_d  out  4  nibble to the seven-segment decoder D3..D0.
REQ-011 dec_point  out  1  point input to the decoder.
REQ-012 dec_le  out  1  decoder blank/latch-enable; 1 = segments dark.
REQ-013 an  out  4  digit anodes, active-low; at most one bit SHALL be 0 in any cycle.
REQ-014 frame_tick  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DRIVE and GUARD.
REQ-016 All outputs SHALL be registered.
REQ-017 A transfer SHALL occur only on a cycle with load=1 and ready=1; the 24-bit word is then captured into a pending register and ready SHALL be 0 from the next cycle.
REQ-018 load while ready=0 SHALL be ignored; the word is neither captured nor queued.
REQ-019 Pending SHALL be committed to the shadow register on the next cycle while in IDLE, or at a frame boundary while in any other state; ready SHALL return to 1 the cycle after commit.
REQ-020 IDLE SHALL hold an=1111 and dec_le=1, and SHALL move to DRIVE with digit index 0 on the cycle after the first commit.
REQ-021 DRIVE with index k SHALL hold an[k]=0 (others 1), dec_d=shadow nibble k, dec_point=points[k] and dec_le=blank[k], for exactly DWELL cycles, then go to GUARD.
REQ-022 GUARD SHALL hold an=1111 and dec_le=1, with dec_d and dec_point unchanged, for exactly GUARD cycles.
REQ-023 On leaving GUARD the index SHALL become (k+1) mod 4 and the FSM SHALL return to DRIVE.
REQ-024 Frame boundary = the last GUARD cycle with k=3: frame_tick=1 that cycle and the pending commit (if any) SHALL take effect there, so a new word first displays on digit 0.
REQ-025 A frame SHALL last exactly 4*(DWELL+GUARD) cycles.
REQ-026 If load and a commit coincide, the commit SHALL win and the load is ignored (ready was 0).
REQ-027 The shadow register SHALL never change mid-frame (no tearing).

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, an=1111, dec_d=0, dec_point=0, dec_le=1, frame_tick=0, ready=1, index 0, pending empty, shadow 0, timer 0.
REQ-029 Reset asserted mid-frame SHALL abort the scan; after release the block SHALL wait in IDLE for a new load.

Structure
REQ-030 Package disp_scan_pkg SHALL hold the state enum, NUM_DIGITS=4 and the word-width constant (24).
REQ-031 Sub-module scan_timer SHALL implement a loadable down-counter of width $clog2(max(DWELL,GUARD)+1) with a done output; the FSM SHALL load it with DWELL or GUARD on each state entry.

Verification (DWELL=4, GUARD=2)
REQ-032 Reset, then load hexs=16'h1234, points=0001, blank=0000 -> ready=0 one cycle, then DRIVE: an=1110 with dec_d=4 and dec_point=1 for 4 cycles, then an=1111 for 2 cycles, then an=1101 with dec_d=3.
REQ-033 Free-run -> frame_tick period exactly 24 cycles; an never has two 0 bits; the an sequence is 1110,1111,1101,1111,1011,1111,0111,1111.
REQ-034 Second load (16'hABCD) mid-frame -> display stays 1234 until frame_tick; the next digit 0 shows D; ready rises the cycle after frame_tick.
REQ-035 load held high while ready=0 with changing data -> only the word present on the accepting cycle is displayed.
REQ-036 blank=0100 -> dec_le=1 throughout digit 2's DRIVE, and an[2]=0 still sequences normally.
REQ-037 rst_n pulsed low during digit 2 DRIVE -> an=1111 and dec_le=1 asynchronously; the block stays IDLE until the next load.
